// File: rtl/game_pkg.sv
// Shared game definitions: checker FSM encoding, geometry defaults and score helpers.
package game_pkg;

    localparam int DEF_PIPE_W   = 52;
    localparam int DEF_GAP_H    = 100;
    localparam int DEF_BIRD_HX  = 12;
    localparam int DEF_BIRD_HY  = 17;
    localparam int DEF_GROUND_X = 104;
    localparam int DEF_SPEED    = 5;

    localparam int NUM_PIPES = 3;
    localparam int SCORE_W   = 10;
    localparam int SCORE_MAX = 999;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LATCH,
        S_P1,
        S_P2,
        S_P3,
        S_FIN
    } state_t;

    typedef logic signed [15:0] pos_t;
    typedef logic signed [16:0] wide_t;
    typedef logic [SCORE_W-1:0] score_t;

    typedef struct packed {
        pos_t x;
        pos_t y;
    } point_t;

    // Sign-extend a screen coordinate so sums and differences cannot wrap.
    function automatic wide_t widen(input pos_t v);
        return {v[15], v};
    endfunction

    function automatic score_t sat_add(input score_t s, input logic [1:0] n);
        logic [SCORE_W:0] sum;
        sum = {1'b0, s} + {{(SCORE_W-1){1'b0}}, n};
        return (sum > (SCORE_W+1)'(SCORE_MAX)) ? SCORE_W'(SCORE_MAX) : sum[SCORE_W-1:0];
    endfunction

endpackage

// File: rtl/collision_check_if.sv
// Bundle between the game controller (master) and the collision checker (slave).
interface collision_check_if;
    import game_pkg::*;

    logic   new_frame;
    logic   check_en;
    logic   clr;
    pos_t   bird_pos_x;
    pos_t   bird_pos_y;
    pos_t   pipe1_pos_x;
    pos_t   pipe1_pos_y;
    pos_t   pipe2_pos_x;
    pos_t   pipe2_pos_y;
    pos_t   pipe3_pos_x;
    pos_t   pipe3_pos_y;
    logic   dead;
    score_t score;
    logic   score_pulse;
    logic   busy;
    logic   done;
    logic   overrun;

    modport master (
        output new_frame, check_en, clr,
        output bird_pos_x, bird_pos_y,
        output pipe1_pos_x, pipe1_pos_y, pipe2_pos_x, pipe2_pos_y, pipe3_pos_x, pipe3_pos_y,
        input  dead, score, score_pulse, busy, done, overrun
    );

    modport slave (
        input  new_frame, check_en, clr,
        input  bird_pos_x, bird_pos_y,
        input  pipe1_pos_x, pipe1_pos_y, pipe2_pos_x, pipe2_pos_y, pipe3_pos_x, pipe3_pos_y,
        output dead, score, score_pulse, busy, done, overrun
    );

endinterface

// File: rtl/pipe_test.sv
// Combinational bird-versus-one-pipe test: collision with the pipe body and pass detection.
module pipe_test
    import game_pkg::*;
#(
    parameter int PIPE_W  = DEF_PIPE_W,
    parameter int GAP_H   = DEF_GAP_H,
    parameter int BIRD_HX = DEF_BIRD_HX,
    parameter int BIRD_HY = DEF_BIRD_HY,
    parameter int SPEED   = DEF_SPEED
) (
    input  point_t bird,
    input  point_t pipe,
    output logic   hit,
    output logic   pass
);

    localparam wide_t K_PW1 = wide_t'(PIPE_W - 1);
    localparam wide_t K_GH1 = wide_t'(GAP_H - 1);
    localparam wide_t K_HX  = wide_t'(BIRD_HX);
    localparam wide_t K_HY  = wide_t'(BIRD_HY);
    localparam wide_t K_SPD = wide_t'(SPEED);

    wide_t bx, by, px, py;
    wide_t bird_lo, bird_hi, pipe_top;
    logic  overlap;

    always_comb begin
        bx = widen(bird.x);
        by = widen(bird.y);
        px = widen(pipe.x);
        py = widen(pipe.y);

        bird_lo  = by - K_HY;
        bird_hi  = by + K_HY;
        pipe_top = py + K_PW1;

        overlap = (py <= bird_hi) && (pipe_top >= bird_lo);
        // Inside the pipe's column the bird must fit entirely within the gap.
        hit  = overlap && ((bx - K_HX < px) || (bx + K_HX > px + K_GH1));
        // The trailing edge crossed the bird's rear edge during the last advance.
        pass = (bird_lo - K_SPD <= pipe_top) && (pipe_top < bird_lo);
    end

endmodule

// File: rtl/collision_check.sv
// Per-frame collision and scoring checker: snapshots positions, tests three pipes in turn.
module collision_check
    import game_pkg::*;
#(
    parameter int PIPE_W   = DEF_PIPE_W,
    parameter int GAP_H    = DEF_GAP_H,
    parameter int BIRD_HX  = DEF_BIRD_HX,
    parameter int BIRD_HY  = DEF_BIRD_HY,
    parameter int GROUND_X = DEF_GROUND_X,
    parameter int SPEED    = DEF_SPEED
) (
    input logic              clk,
    input logic              rst,
    collision_check_if.slave bus
);

    state_t     state, next_state;
    point_t     snap_bird;
    point_t     snap_pipe [NUM_PIPES];
    point_t     cur_pipe;
    logic       busy, in_pipe;
    logic       pipe_hit, pipe_pass;
    logic       hit_acc;
    logic [1:0] pass_cnt;
    logic       ground_hit, any_hit;
    logic       dead, score_pulse, done, overrun;
    score_t     score;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            S_IDLE:  if (bus.new_frame && bus.check_en) next_state = S_LATCH;
            S_LATCH: next_state = S_P1;
            S_P1:    next_state = S_P2;
            S_P2:    next_state = S_P3;
            S_P3:    next_state = S_FIN;
            S_FIN:   next_state = S_IDLE;
            default: next_state = S_IDLE;
        endcase
    end

    always_comb begin
        busy     = (state != S_IDLE);
        in_pipe  = 1'b0;
        cur_pipe = snap_pipe[0];
        case (state)
            S_P1: in_pipe = 1'b1;
            S_P2: begin in_pipe = 1'b1; cur_pipe = snap_pipe[1]; end
            S_P3: begin in_pipe = 1'b1; cur_pipe = snap_pipe[2]; end
            default: ;
        endcase
    end

    pipe_test #(
        .PIPE_W  (PIPE_W),
        .GAP_H   (GAP_H),
        .BIRD_HX (BIRD_HX),
        .BIRD_HY (BIRD_HY),
        .SPEED   (SPEED)
    ) u_pipe_test (
        .bird (snap_bird),
        .pipe (cur_pipe),
        .hit  (pipe_hit),
        .pass (pipe_pass)
    );

    assign ground_hit = (widen(snap_bird.x) <= wide_t'(GROUND_X));
    assign any_hit    = hit_acc | ground_hit;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the snapshot is cleared on reset so no stale positions survive an aborted check.
            snap_bird <= '0;
            for (int i = 0; i < NUM_PIPES; i++) snap_pipe[i] <= '0;
        end else if (state == S_LATCH) begin
            snap_bird    <= '{x: bus.bird_pos_x,  y: bus.bird_pos_y};
            snap_pipe[0] <= '{x: bus.pipe1_pos_x, y: bus.pipe1_pos_y};
            snap_pipe[1] <= '{x: bus.pipe2_pos_x, y: bus.pipe2_pos_y};
            snap_pipe[2] <= '{x: bus.pipe3_pos_x, y: bus.pipe3_pos_y};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hit_acc     <= 1'b0;
            pass_cnt    <= 2'd0;
            dead        <= 1'b0;
            score       <= '0;
            score_pulse <= 1'b0;
            done        <= 1'b0;
            overrun     <= 1'b0;
        end else begin
            done        <= 1'b0;
            score_pulse <= 1'b0;

            if (state == S_LATCH) begin
                hit_acc  <= 1'b0;
                pass_cnt <= 2'd0;
            end
            if (in_pipe) begin
                hit_acc  <= hit_acc | pipe_hit;
                pass_cnt <= pass_cnt + {1'b0, pipe_pass};
            end

            if (busy && bus.new_frame) overrun <= 1'b1;

            if (state == S_FIN) begin
                done <= 1'b1;
                if (any_hit) begin
                    dead <= 1'b1;
                end else if (!dead && pass_cnt != 2'd0) begin
                    score       <= sat_add(score, pass_cnt);
                    score_pulse <= 1'b1;
                end
            end

            // Clear wins over the FIN update but leaves the FSM running.
            if (bus.clr) begin
                dead        <= 1'b0;
                score       <= '0;
                score_pulse <= 1'b0;
                overrun     <= 1'b0;
            end
        end
    end

    assign bus.dead        = dead;
    assign bus.score       = score;
    assign bus.score_pulse = score_pulse;
    assign bus.busy        = busy;
    assign bus.done        = done;
    assign bus.overrun     = overrun;

endmodule
